cart_save_ctrl: RTL and testbench

Backup-RAM sequencer that moves Game Boy cartridge save RAM between the cart RAM back port (bk_*) and the MiSTer SD block interface. On image mount it loads the save file into cart RAM block by block. On a save request it writes cart RAM back to the file, but only when RAM has been modified since the last load or save. It sits directly upstream of cart_top's bk_* port and consumes cart_top's ram_mask_file, has_save and cram_wr.

---
 rtl/cart_pkg.sv | 15 +
 rtl/cart_save_dirty.sv | 28 ++
 rtl/cart_save_ctrl.sv | 148 ++++++++++++++
 tb/tb_cart_save_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge backup-RAM save path.
package cart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK_WAIT,
    ST_DONE_WAIT,
    ST_NEXT
  } cart_state_t;

  localparam int unsigned BLK_BYTES   = 512;
  localparam logic [16:0] RTC_BK_BASE = 17'h10000;

endpackage

// File: rtl/cart_save_dirty.sv
// Dirty and pending-save flags; a RAM write always wins over a clear.
module cart_save_dirty (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic cram_wr,
  input  logic loaded,
  input  logic clr,
  input  logic save_req,
  input  logic defer,
  output logic dirty,
  output logic pending
);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dirty   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (cram_wr && loaded) dirty <= 1'b1;
      else if (clr)          dirty <= 1'b0;

      // A request that cannot start now is remembered until the sequencer is idle again.
      if (save_req && defer) pending <= 1'b1;
      else if (!defer)       pending <= 1'b0;
    end
  end

endmodule

// File: rtl/cart_save_ctrl.sv
// Backup-RAM sequencer between cart RAM back port and the SD block interface.
// Define CART_SAVE_RTC_EN to transfer a trailing RTC block after the RAM blocks.
module cart_save_ctrl
  import cart_pkg::*;
#(
  parameter int unsigned BLK_WORDS = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic [7:0]  ram_mask_file,
  input  logic        has_save,
  input  logic        cram_wr,
  input  logic        save_req,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  output logic [16:0] bk_addr,
  output logic [15:0] bk_data,
  output logic        bk_wr,
  output logic        bk_rtc_wr,
  input  logic [15:0] bk_q,
  output logic        busy,
  output logic        dirty,
  output logic        loaded
);

`ifdef CART_SAVE_RTC_EN
  localparam bit RTC_EN = 1'b1;
`else
  localparam bit RTC_EN = 1'b0;
`endif

  cart_state_t state;
  logic [8:0]  lba;
  logic [7:0]  last;
  logic        dir_wr;
  logic        rtc_phase;
  logic        rtc_has;
  logic        pending;
  logic        load_start_c;
  logic        save_start_c;
  logic        rtc_fits_c;
  logic        xfer_c;

  assign busy = (state != ST_IDLE);

  assign load_start_c = !busy && img_mounted && has_save && (img_size != 64'd0);
  assign save_start_c = !busy && !load_start_c && (save_req || pending) &&
                        loaded && dirty && !img_readonly;

  // Image holds an RTC block when it is larger than the RAM blocks it covers.
  assign rtc_fits_c = img_size > ((64'(ram_mask_file) + 64'd1) * 64'(BLK_WORDS) * 64'd2);

  assign xfer_c = sd_buff_wr && sd_ack && !dir_wr &&
                  ((state == ST_ACK_WAIT) || (state == ST_DONE_WAIT));

  assign sd_lba      = 32'(lba);
  assign bk_addr     = rtc_phase ? (RTC_BK_BASE | 17'(sd_buff_addr)) : {1'b0, lba[7:0], sd_buff_addr};
  assign bk_data     = sd_buff_dout;
  assign sd_buff_din = bk_q;
  assign bk_wr       = xfer_c && !rtc_phase;

`ifdef CART_SAVE_RTC_EN
  assign bk_rtc_wr = xfer_c && rtc_phase;
`else
  assign bk_rtc_wr = 1'b0;
`endif

  // Block sequencer: one request/ack handshake per SD block.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      lba       <= '0;
      last      <= '0;
      dir_wr    <= 1'b0;
      rtc_phase <= 1'b0;
      rtc_has   <= 1'b0;
      loaded    <= 1'b0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (load_start_c || save_start_c) begin
            state     <= ST_REQ;
            lba       <= '0;
            last      <= ram_mask_file;
            dir_wr    <= save_start_c;
            rtc_phase <= 1'b0;
            rtc_has   <= RTC_EN && rtc_fits_c;
          end
          if (load_start_c) loaded <= 1'b0;
        end
        ST_REQ: begin
          sd_rd <= !dir_wr;
          sd_wr <= dir_wr;
          state <= ST_ACK_WAIT;
        end
        ST_ACK_WAIT: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_DONE_WAIT;
          end
        end
        ST_DONE_WAIT: begin
          if (!sd_ack) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (!rtc_phase && (lba[7:0] != last)) begin
            lba   <= lba + 9'd1;
            state <= ST_REQ;
          end else if (!rtc_phase && rtc_has) begin
            rtc_phase <= 1'b1;
            lba       <= lba + 9'd1;
            state     <= ST_REQ;
          end else begin
            rtc_phase <= 1'b0;
            state     <= ST_IDLE;
            if (!dir_wr) loaded <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cart_save_dirty u_dirty (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .cram_wr  (cram_wr),
    .loaded   (loaded),
    .clr      (load_start_c || save_start_c),
    .save_req (save_req),
    .defer    (busy || load_start_c),
    .dirty    (dirty),
    .pending  (pending)
  );

endmodule

// File: tb/tb_cart_save_ctrl.sv
// Directed bench for cart_save_ctrl: SD host model plus a 1-cycle dpram model on the back port.
module tb_cart_save_ctrl;
  import cart_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        img_mounted, img_readonly, has_save, cram_wr, save_req;
  logic [63:0] img_size;
  logic [7:0]  ram_mask_file;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr;
  logic [16:0] bk_addr;
  logic [15:0] bk_data, bk_q;
  logic        bk_wr, bk_rtc_wr, busy, dirty, loaded;

  logic [15:0] mem [0:131071];
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt, rtc_cnt, served, err, seen;

  always #5 clk_sys = ~clk_sys;

  cart_save_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size), .ram_mask_file(ram_mask_file), .has_save(has_save), .cram_wr(cram_wr),
    .save_req(save_req), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .bk_addr(bk_addr), .bk_data(bk_data), .bk_wr(bk_wr),
    .bk_rtc_wr(bk_rtc_wr), .bk_q(bk_q), .busy(busy), .dirty(dirty), .loaded(loaded)
  );

  // Cart RAM read port with one cycle of latency.
  always @(posedge clk_sys) bk_q <= mem[bk_addr];

  function automatic logic [15:0] pat(input int b, input int i);
    return {8'(b), 8'(i)} ^ 16'hC35A;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_save();
    save_req = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
  endtask

  task automatic pulse_cram();
    cram_wr = 1'b1;
    @(negedge clk_sys);
    cram_wr = 1'b0;
  endtask

  task automatic mount(input logic [63:0] size);
    img_size    = size;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
  endtask

  task automatic watch(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk_sys);
      if (busy || sd_rd || sd_wr) cnt++;
    end
  endtask

  // Serve n block requests; when serve_last=0 return as soon as the n-th request appears.
  task automatic run_seq(input int n, input bit exp_wr, input bit serve_last, input int poke_lba,
                         input bit poke_cram, input int rtc_lba, output int nsrv, output int nerr);
    int t;
    bit is_rtc;
    logic [16:0] exp_addr;
    nsrv = 0;
    nerr = 0;
    for (int b = 0; b < n; b++) begin
      t = 0;
      while (!(sd_rd || sd_wr) && t < 100) begin
        @(negedge clk_sys);
        t++;
      end
      if (t >= 100) begin
        nerr++;
        break;
      end
      if (sd_lba != 32'(b)) nerr++;
      if (sd_wr != exp_wr || sd_rd != !exp_wr) nerr++;
      if (!serve_last && b == n - 1) break;
      repeat (2) @(negedge clk_sys);
      if (!(sd_rd || sd_wr)) nerr++;
      sd_ack = 1'b1;
      @(negedge clk_sys);
      if (sd_rd || sd_wr) nerr++;
      if (b == poke_lba) begin
        save_req = 1'b1;
        cram_wr  = poke_cram;
        @(negedge clk_sys);
        save_req = 1'b0;
        cram_wr  = 1'b0;
      end
      if (!exp_wr) begin
        is_rtc = (b == rtc_lba);
        for (int i = 0; i < 256; i++) begin
          sd_buff_addr = 8'(i);
          sd_buff_dout = pat(b, i);
          sd_buff_wr   = 1'b1;
          #1;
          exp_addr = is_rtc ? (RTC_BK_BASE | 17'(i)) : {1'b0, 8'(b), 8'(i)};
          if (bk_wr) wr_cnt++;
          if (bk_rtc_wr) rtc_cnt++;
          if (bk_wr === is_rtc || bk_rtc_wr !== is_rtc || bk_addr !== exp_addr || bk_data !== pat(b, i))
            nerr++;
          if (bk_wr || bk_rtc_wr) mem[bk_addr] = bk_data;
          @(negedge clk_sys);
        end
        sd_buff_wr = 1'b0;
      end else begin
        for (int i = 0; i < 256; i++) begin
          sd_buff_addr = 8'(i);
          @(negedge clk_sys);
          if (sd_buff_din !== pat(b, i)) nerr++;
        end
      end
      sd_ack = 1'b0;
      nsrv++;
    end
    if (serve_last) begin
      t = 0;
      while (busy && t < 20) begin
        @(negedge clk_sys);
        t++;
      end
      if (busy) nerr++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0; has_save = 1'b1;
    cram_wr = 1'b0; save_req = 1'b0; img_size = 64'd0; ram_mask_file = 8'h0F;
    sd_ack = 1'b0; sd_buff_addr = 8'd0; sd_buff_dout = 16'd0; sd_buff_wr = 1'b0;
    wr_cnt = 0; rtc_cnt = 0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("rst_sd_rd", 64'(sd_rd), 64'd0);
    check("rst_sd_wr", 64'(sd_wr), 64'd0);
    check("rst_sd_lba", 64'(sd_lba), 64'd0);
    check("rst_bk_wr", 64'({bk_wr, bk_rtc_wr}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dirty", 64'(dirty), 64'd0);
    check("rst_loaded", 64'(loaded), 64'd0);

    // Load 16 blocks
    mount(64'(16 * BLK_BYTES));
    check("mount_busy", 64'(busy), 64'd1);
    check("mount_rd_early", 64'(sd_rd), 64'd0);
    @(negedge clk_sys);
    check("mount_rd_rise", 64'(sd_rd), 64'd1);
    run_seq(16, 1'b0, 1'b1, -1, 1'b0, -1, served, err);
    check("load_blocks", 64'(served), 64'd16);
    check("load_err", 64'(err), 64'd0);
    check("load_bk_wr", 64'(wr_cnt), 64'd4096);
    check("load_loaded", 64'(loaded), 64'd1);
    check("load_dirty", 64'(dirty), 64'd0);

    // Clean RAM: save request ignored
    pulse_save();
    watch(20, seen);
    check("clean_no_save", 64'(seen), 64'd0);

    // Read-only image blocks a dirty save
    pulse_cram();
    check("cram_dirty", 64'(dirty), 64'd1);
    img_readonly = 1'b1;
    pulse_save();
    watch(20, seen);
    check("ro_no_save", 64'(seen), 64'd0);
    check("ro_dirty_kept", 64'(dirty), 64'd1);
    img_readonly = 1'b0;

    // Dirty save writes back loaded data
    pulse_save();
    check("save_dirty_clr", 64'(dirty), 64'd0);
    run_seq(16, 1'b1, 1'b1, -1, 1'b0, -1, served, err);
    check("save_blocks", 64'(served), 64'd16);
    check("save_err", 64'(err), 64'd0);

    // RAM write on the save-start cycle keeps dirty set
    pulse_cram();
    save_req = 1'b1;
    cram_wr  = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
    cram_wr  = 1'b0;
    check("coinc_busy", 64'(busy), 64'd1);
    check("coinc_dirty", 64'(dirty), 64'd1);
    run_seq(16, 1'b1, 1'b1, -1, 1'b0, -1, served, err);
    check("coinc_err", 64'({16'(served), 16'(err)}), 64'h0010_0000);
    check("coinc_dirty_after", 64'(dirty), 64'd1);

    // save_req plus RAM write mid-save: pending save reruns automatically
    pulse_save();
    check("pend_dirty_clr", 64'(dirty), 64'd0);
    run_seq(16, 1'b1, 1'b1, 3, 1'b1, -1, served, err);
    check("pend_first_err", 64'({16'(served), 16'(err)}), 64'h0010_0000);
    run_seq(16, 1'b1, 1'b1, -1, 1'b0, -1, served, err);
    check("pend_rerun_err", 64'({16'(served), 16'(err)}), 64'h0010_0000);
    check("pend_rerun_dirty", 64'(dirty), 64'd0);

    // save_req during a load: dropped because RAM is clean afterwards
    mount(64'(16 * BLK_BYTES));
    run_seq(16, 1'b0, 1'b1, 3, 1'b0, -1, served, err);
    check("reload_err", 64'({16'(served), 16'(err)}), 64'h0010_0000);
    check("reload_dirty", 64'(dirty), 64'd0);
    watch(20, seen);
    check("pend_load_no_save", 64'(seen), 64'd0);
    pulse_cram();
    watch(20, seen);
    check("cram_no_autosave", 64'(seen), 64'd0);
    check("cram_dirty2", 64'(dirty), 64'd1);

    // Reset while the lba 5 read request is up
    mount(64'(16 * BLK_BYTES));
    run_seq(6, 1'b0, 1'b0, -1, 1'b0, -1, served, err);
    check("rstmid_err", 64'({16'(served), 16'(err)}), 64'h0005_0000);
    check("rstmid_rd_before", 64'(sd_rd), 64'd1);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check("rstmid_rd", 64'(sd_rd), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_loaded", 64'(loaded), 64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Image one block larger than the RAM blocks
    wr_cnt  = 0;
    rtc_cnt = 0;
    mount(64'(17 * BLK_BYTES));
`ifdef CART_SAVE_RTC_EN
    run_seq(17, 1'b0, 1'b1, -1, 1'b0, 16, served, err);
    check("rtc_load_blocks", 64'(served), 64'd17);
    check("rtc_load_err", 64'(err), 64'd0);
    check("rtc_bk_wr", 64'(wr_cnt), 64'd4096);
    check("rtc_bk_rtc_wr", 64'(rtc_cnt), 64'd256);
    check("rtc_dirty", 64'(dirty), 64'd0);
    check("rtc_loaded", 64'(loaded), 64'd1);
    pulse_cram();
    pulse_save();
    run_seq(17, 1'b1, 1'b1, -1, 1'b0, 16, served, err);
    check("rtc_save_err", 64'({16'(served), 16'(err)}), 64'h0011_0000);
`else
    run_seq(16, 1'b0, 1'b1, -1, 1'b0, -1, served, err);
    check("big_load_err", 64'({16'(served), 16'(err)}), 64'h0010_0000);
    check("big_bk_wr", 64'(wr_cnt), 64'd4096);
    check("big_no_rtc", 64'(rtc_cnt), 64'd0);
    watch(20, seen);
    check("big_no_extra", 64'(seen), 64'd0);
    check("big_loaded", 64'(loaded), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
